intersection_phase_scheduler: RTL and testbench
===============================================

INTERSECTION_PHASE_SCHEDULER -- requirements
Module: intersection_phase_scheduler

Interface
REQ-001 The block SHALL have parameter MIN_GREEN, default 4, giving the minimum green cycles for any road phase (legal range 1..255).
REQ-002 The block SHALL have parameter MAX_GREEN, default 8, giving the maximum local-road green cycles (legal range MIN_GREEN..255).
REQ-003 The block SHALL have parameter YELLOW_CYC, default 2, giving the yellow duration in cycles (legal range 1..255).
REQ-004 The block SHALL have parameter ALLRED_CYC, default 1, giving the all-red clearance in cycles (legal range 1..255).
REQ-005 The block SHALL have parameter WALK_CYC, default 3, giving the pedestrian walk duration in cycles (legal range 1..255).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port lr_has_car, input, 1 bit: level request from the local-road sensor.
REQ-009 The block SHALL have port ped_req, input, 1 bit: pedestrian button, single-cycle pulse or level.
REQ-010 The block SHALL have port hw_light, output, 3 bits: highway lamp; 3'b100 green, 3'b010 yellow, 3'b001 red.
REQ-011 The block SHALL have port lr_light, output, 3 bits: local-road lamp, using the same encoding as hw_light.
REQ-012 The block SHALL have port ped_walk, output, 1 bit: pedestrian walk lamp.
REQ-013 The block SHALL have port phase, output, 3 bits: current state code, for debug.

Function
REQ-014 The block SHALL implement the states HW_GREEN=0, HW_YELLOW=1, ALL_RED=2, LR_GREEN=3, LR_YELLOW=4 and PED_WALK=5; codes 6-7 SHALL go to HW_GREEN on the next cycle.
REQ-015 All outputs SHALL be Moore decodes of the state register: only the active road shows green or yellow, every other lamp shows red, and ped_walk=1 only in PED_WALK.
REQ-016 An 8-bit dwell counter SHALL be cleared to 0 on every state change and SHALL increment once per cycle while the state is unchanged.
REQ-017 In HW_GREEN, when dwell>=MIN_GREEN-1 and (lr_has_car or ped_pending), the block SHALL go to HW_YELLOW; otherwise it SHALL stay in HW_GREEN indefinitely.
REQ-018 In HW_YELLOW and LR_YELLOW, when dwell==YELLOW_CYC-1, the block SHALL go to ALL_RED.
REQ-019 On every entry to ALL_RED, a target register SHALL be latched: from HW_YELLOW it holds the arbitration winner; from LR_YELLOW or PED_WALK it holds HW.
REQ-020 Arbitration: if only lr_has_car is asserted, the winner SHALL be LR; if only ped_pending is set, PED; if both, the side not served last (last_served flag); if neither (request withdrawn), HW.
REQ-021 In ALL_RED, when dwell==ALLRED_CYC-1, the block SHALL go to the latched target: HW_GREEN, LR_GREEN or PED_WALK.
REQ-022 In LR_GREEN, when (dwell>=MIN_GREEN-1 and !lr_has_car) or dwell==MAX_GREEN-1, the block SHALL go to LR_YELLOW.
REQ-023 In PED_WALK, when dwell==WALK_CYC-1, the block SHALL go to ALL_RED.
REQ-024 ped_pending SHALL be set by ped_req=1 in any cycle and cleared in the cycle the block enters PED_WALK; a ped_req arriving in that same entry cycle SHALL be absorbed.
REQ-025 last_served SHALL be set to LR on entry to LR_GREEN and to PED on entry to PED_WALK.
REQ-026 The block SHALL never show green or walk on two crossings simultaneously, and every green SHALL be preceded by at least ALLRED_CYC all-red cycles, except the HW green forced by reset.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL set the state to HW_GREEN, dwell to 0, ped_pending to 0, last_served to PED and target to HW, overriding all other events.
REQ-028 In the first cycle after reset, outputs SHALL be hw_light=100, lr_light=001, ped_walk=0 and phase=0, including when reset is asserted mid-phase.

Configuration
REQ-029 With macro PED_CROSSING_EN defined, the PED_WALK state, ped_pending and last_served SHALL be present as specified above.
REQ-030 Without PED_CROSSING_EN, ped_req SHALL be ignored, ped_pending SHALL be constant 0, ped_walk SHALL be tied to 0, PED_WALK SHALL be unreachable, and arbitration SHALL reduce to LR-or-HW.

Verification
REQ-031 The bench SHALL check: rst for 2 cycles, then lr_has_car=0 and ped_req=0 for 100 cycles -> hw_light=100 and lr_light=001 throughout.
REQ-032 The bench SHALL check: lr_has_car=1 constantly from the first cycle after reset (cycle 0) -> HW green in cycles 0-3, HW yellow in 4-5, all-red in 6, LR green in 7-14 (MAX_GREEN cap), LR yellow in 15-16, all-red in 17, HW green in 18-21, then repeat.
REQ-033 The bench SHALL check, with PED_CROSSING_EN defined: a ped_req pulse in cycle 1 with lr_has_car=0 -> HW yellow in cycles 4-5, all-red in 6, ped_walk=1 with both roads red in 7-9, all-red in 10, HW green from 11.
REQ-034 The bench SHALL check: lr_has_car=1 plus ped_req pulses every 5 cycles -> granted phases alternate LR, PED, LR, PED, and the HW green between them is at least 4 cycles each time.
REQ-035 The bench SHALL check: rst pulsed for 1 cycle in the third cycle of LR_GREEN -> in the next cycle phase=0, hw_light=100 and lr_light=001, and the pending ped request is lost.
REQ-036 The bench SHALL check, without PED_CROSSING_EN: ped_req held at 1 for 200 cycles with lr_has_car=0 -> ped_walk=0 and hw_light=100 throughout.

Source files
------------

// File: rtl/intersection_phase_scheduler.sv
// Highway / local-road / pedestrian phase scheduler with dwell-timed phases.
// Optional pedestrian crossing enabled by defining PED_CROSSING_EN.
module intersection_phase_scheduler #(
   parameter int MIN_GREEN  = 4,
   parameter int MAX_GREEN  = 8,
   parameter int YELLOW_CYC = 2,
   parameter int ALLRED_CYC = 1,
   parameter int WALK_CYC   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lr_has_car,
   input  logic       ped_req,
   output logic [2:0] hw_light,
   output logic [2:0] lr_light,
   output logic       ped_walk,
   output logic [2:0] phase
);

   localparam logic [2:0] HW_GREEN  = 3'd0;
   localparam logic [2:0] HW_YELLOW = 3'd1;
   localparam logic [2:0] ALL_RED   = 3'd2;
   localparam logic [2:0] LR_GREEN  = 3'd3;
   localparam logic [2:0] LR_YELLOW = 3'd4;
   localparam logic [2:0] PED_WALK  = 3'd5;

   localparam logic [1:0] T_HW  = 2'd0;
   localparam logic [1:0] T_LR  = 2'd1;
   localparam logic [1:0] T_PED = 2'd2;

   localparam logic [7:0] MIN_M1 = 8'(MIN_GREEN - 1);
   localparam logic [7:0] MAX_M1 = 8'(MAX_GREEN - 1);
   localparam logic [7:0] YEL_M1 = 8'(YELLOW_CYC - 1);
   localparam logic [7:0] AR_M1  = 8'(ALLRED_CYC - 1);
   localparam logic [7:0] WLK_M1 = 8'(WALK_CYC - 1);

   localparam logic [2:0] LAMP_G = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_R = 3'b001;

   logic [2:0] state;
   logic [2:0] nxt;
   logic [7:0] dwell;
   logic [1:0] target;
   logic [1:0] winner;
   logic       ped_pending;
   logic       last_served;   // 1: pedestrians served last, 0: local road

`ifdef PED_CROSSING_EN
   logic enter_walk;
   assign enter_walk = (nxt == PED_WALK) && (state != PED_WALK);

   // Pedestrian request memory and fairness flag
   always_ff @(posedge clk) begin
      if (rst) begin
         ped_pending <= 1'b0;
         last_served <= 1'b1;
      end else begin
         if (enter_walk)
            ped_pending <= 1'b0;
         else if (ped_req)
            ped_pending <= 1'b1;
         if (enter_walk)
            last_served <= 1'b1;
         else if (nxt == LR_GREEN && state != LR_GREEN)
            last_served <= 1'b0;
      end
   end
`else
   logic unused_ped;
   assign unused_ped  = ped_req;
   assign ped_pending = 1'b0;
   assign last_served = 1'b1;
`endif

   // Pick who gets the crossing when highway yields
   always_comb begin
      winner = T_HW;
      case ({lr_has_car, ped_pending})
         2'b10:   winner = T_LR;
         2'b01:   winner = T_PED;
         2'b11:   winner = last_served ? T_LR : T_PED;
         default: winner = T_HW;
      endcase
   end

   // Phase transition rules
   always_comb begin
      nxt = state;
      case (state)
         HW_GREEN:
            if (dwell >= MIN_M1 && (lr_has_car || ped_pending))
               nxt = HW_YELLOW;
         HW_YELLOW:
            if (dwell == YEL_M1) nxt = ALL_RED;
         ALL_RED:
            if (dwell == AR_M1) begin
               case (target)
                  T_LR:    nxt = LR_GREEN;
`ifdef PED_CROSSING_EN
                  T_PED:   nxt = PED_WALK;
`endif
                  default: nxt = HW_GREEN;
               endcase
            end
         LR_GREEN:
            if ((dwell >= MIN_M1 && !lr_has_car) || dwell == MAX_M1)
               nxt = LR_YELLOW;
         LR_YELLOW:
            if (dwell == YEL_M1) nxt = ALL_RED;
`ifdef PED_CROSSING_EN
         PED_WALK:
            if (dwell == WLK_M1) nxt = ALL_RED;
`endif
         default: nxt = HW_GREEN;
      endcase
   end

   // State, dwell timer and all-red target register
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= HW_GREEN;
         dwell  <= 8'd0;
         target <= T_HW;
      end else begin
         state <= nxt;
         dwell <= (nxt != state) ? 8'd0 : dwell + 8'd1;
         if (nxt == ALL_RED && state != ALL_RED)
            target <= (state == HW_YELLOW) ? winner : T_HW;
      end
   end

   // Moore lamp decode
   always_comb begin
      hw_light = LAMP_R;
      lr_light = LAMP_R;
      ped_walk = 1'b0;
      case (state)
         HW_GREEN:  hw_light = LAMP_G;
         HW_YELLOW: hw_light = LAMP_Y;
         LR_GREEN:  lr_light = LAMP_G;
         LR_YELLOW: lr_light = LAMP_Y;
         PED_WALK:  ped_walk = 1'b1;
         default:   ped_walk = 1'b0;
      endcase
   end

   assign phase = state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler (default parameters).
// Pedestrian scenarios follow PED_CROSSING_EN.
module tb_intersection_phase_scheduler;

   logic       clk = 1'b0;
   logic       rst;
   logic       lr_has_car;
   logic       ped_req;
   logic [2:0] hw_light;
   logic [2:0] lr_light;
   logic       ped_walk;
   logic [2:0] phase;

   int vectors = 0;
   int miscompares = 0;

   intersection_phase_scheduler dut (
      .clk        (clk),
      .rst        (rst),
      .lr_has_car (lr_has_car),
      .ped_req    (ped_req),
      .hw_light   (hw_light),
      .lr_light   (lr_light),
      .ped_walk   (ped_walk),
      .phase      (phase)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int cyc,
                      input logic [7:0] got, input logic [7:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d observed=%0h expected=%0h",
                tag, cyc, got, exp);
      end
   endtask

   function automatic logic [2:0] hw_of(input logic [2:0] ph);
      case (ph)
         3'd0:    return 3'b100;
         3'd1:    return 3'b010;
         default: return 3'b001;
      endcase
   endfunction

   function automatic logic [2:0] lr_of(input logic [2:0] ph);
      case (ph)
         3'd3:    return 3'b100;
         3'd4:    return 3'b010;
         default: return 3'b001;
      endcase
   endfunction

   task automatic check_phase(input string tag, input int k,
                              input logic [2:0] ep);
      chk({tag, "_phase"}, k, 8'(phase), 8'(ep));
      chk({tag, "_hw"}, k, 8'(hw_light), 8'(hw_of(ep)));
      chk({tag, "_lr"}, k, 8'(lr_light), 8'(lr_of(ep)));
      chk({tag, "_walk"}, k, 8'(ped_walk), 8'(ep == 3'd5));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      lr_has_car = 1'b0;
      ped_req = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Constant local-road demand: 18-cycle cycle with MAX_GREEN cap
   function automatic logic [2:0] cycle_exp(input int k);
      int m;
      m = k % 18;
      if (m <= 3)  return 3'd0;
      if (m <= 5)  return 3'd1;
      if (m == 6)  return 3'd2;
      if (m <= 14) return 3'd3;
      if (m <= 16) return 3'd4;
      return 3'd2;
   endfunction

   initial begin
      logic [2:0] ep;
      rst = 1'b1;
      lr_has_car = 1'b0;
      ped_req = 1'b0;

      // Idle after 2-cycle reset: highway green throughout
      do_reset(2);
      for (int k = 0; k < 100; k++) begin
         check_phase("idle", k, 3'd0);
         tick();
      end

      // Constant local-road demand
      do_reset(2);
      lr_has_car = 1'b1;
      for (int k = 0; k < 40; k++) begin
         check_phase("lrcyc", k, cycle_exp(k));
         tick();
      end

      // Car arrives long after MIN_GREEN: yields next cycle
      do_reset(2);
      for (int k = 0; k < 25; k++) begin
         lr_has_car = (k >= 20);
         if (k <= 20)      ep = 3'd0;
         else if (k <= 22) ep = 3'd1;
         else if (k == 23) ep = 3'd2;
         else              ep = 3'd3;
         check_phase("late", k, ep);
         tick();
      end

      // Request withdrawn before arbitration: back to highway
      do_reset(2);
      for (int k = 0; k < 11; k++) begin
         lr_has_car = (k == 3);
         if (k <= 3)      ep = 3'd0;
         else if (k <= 5) ep = 3'd1;
         else if (k == 6) ep = 3'd2;
         else             ep = 3'd0;
         check_phase("withdraw", k, ep);
         tick();
      end

      // Local road leaves early: held to MIN_GREEN
      do_reset(2);
      for (int k = 0; k < 17; k++) begin
         lr_has_car = (k <= 5);
         if (k <= 3)       ep = 3'd0;
         else if (k <= 5)  ep = 3'd1;
         else if (k == 6)  ep = 3'd2;
         else if (k <= 10) ep = 3'd3;
         else if (k <= 12) ep = 3'd4;
         else if (k == 13) ep = 3'd2;
         else              ep = 3'd0;
         check_phase("lrmin", k, ep);
         tick();
      end

      // Reset mid local green drops the pending ped request
      do_reset(2);
      lr_has_car = 1'b1;
      for (int k = 0; k < 10; k++) begin
         check_phase("prerst", k, cycle_exp(k));
         if (k == 8) ped_req = 1'b1;
         if (k == 9) begin
            ped_req = 1'b0;
            rst = 1'b1;
         end
         tick();
      end
      rst = 1'b0;
      lr_has_car = 1'b0;
      for (int k = 0; k < 10; k++) begin
         check_phase("postrst", k, 3'd0);
         tick();
      end

`ifdef PED_CROSSING_EN
      // Single ped pulse, no cars
      do_reset(2);
      for (int k = 0; k < 16; k++) begin
         ped_req = (k == 1);
         if (k <= 3)      ep = 3'd0;
         else if (k <= 5) ep = 3'd1;
         else if (k == 6) ep = 3'd2;
         else if (k <= 9) ep = 3'd5;
         else if (k == 10) ep = 3'd2;
         else             ep = 3'd0;
         check_phase("ped", k, ep);
         tick();
      end

      // Car plus periodic ped pulses: grants alternate
      begin
         int grants[$];
         int run;
         int last_run;
         logic [2:0] prev;
         do_reset(2);
         lr_has_car = 1'b1;
         run = 0;
         last_run = 0;
         prev = 3'd0;
         for (int k = 0; k < 80; k++) begin
            ped_req = (k % 5 == 1);
            if (phase == 3'd0) run++;
            else if (prev == 3'd0) begin
               last_run = run;
               run = 0;
            end
            if (phase != prev && (phase == 3'd3 || phase == 3'd5)) begin
               grants.push_back(int'(phase));
               chk("hwrun", k, 8'(last_run >= 4), 8'd1);
            end
            prev = phase;
            tick();
         end
         ped_req = 1'b0;
         chk("grantcnt", 0, 8'(grants.size() >= 4), 8'd1);
         if (grants.size() >= 4) begin
            chk("grant0", 0, 8'(grants[0]), 8'd3);
            chk("grant1", 1, 8'(grants[1]), 8'd5);
            chk("grant2", 2, 8'(grants[2]), 8'd3);
            chk("grant3", 3, 8'(grants[3]), 8'd5);
         end
      end
`else
      // Ped button ignored when crossing disabled
      do_reset(2);
      ped_req = 1'b1;
      for (int k = 0; k < 200; k++) begin
         check_phase("pedoff", k, 3'd0);
         tick();
      end
      ped_req = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
